// File: rtl/spad_pkg.sv
// Shared definitions for the scratchpad fill controller: FSM state encoding
// and the default scratchpad depth.
package spad_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int SPAD_DEFAULT_DEPTH = 12;

endpackage

// File: rtl/spad_addr_counter.sv
// Write-address / fill-length counter: latches the normalised pass length and
// wrap mode on load, then increments per write with ring wrap or saturation.
module spad_addr_counter #(
  parameter int DEPTH      = 12,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  clr,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   len_in,
  input  logic                  wrap_in,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  last,
  output logic                  wrap_q
);

  localparam int              CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_V = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE     = CW'(1);

  logic [CW-1:0] len_q;
  logic [CW-1:0] len_norm;

  // A zero or oversized request means "fill the whole scratchpad".
  always_comb begin
    len_norm = len_in;
    if (len_in == '0 || len_in > DEPTH_V) begin
      len_norm = DEPTH_V;
    end
  end

  assign last = (count == len_q - ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      len_q  <= DEPTH_V;
      wrap_q <= 1'b0;
    end else if (load) begin
      count  <= '0;
      len_q  <= len_norm;
      wrap_q <= wrap_in;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (last) begin
        count <= wrap_q ? '0 : len_q;
      end else if (count < len_q) begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/spad_fill_ctrl.sv
// Scratchpad fill controller: moves entries from a source FIFO into the
// scratchpad, one-shot or as a continuous ring, under upstream buffer control.
module spad_fill_ctrl
  import spad_pkg::*;
#(
  parameter int DEPTH      = SPAD_DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  buffer_ready,
  input  logic                  empty,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  cfg_wrap,
  output logic                  pop,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  ready,
  output logic                  clear,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   fill_count
);

  state_t              state;
  state_t              state_nxt;
  logic                cnt_load;
  logic                cnt_clr;
  logic                cnt_inc;
  logic                cnt_last;
  logic                wrap_q;
  logic [ADDR_WIDTH:0] count;

  spad_addr_counter #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .clk     (clk),
    .rstn    (rstn),
    .load    (cnt_load),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .len_in  (cfg_len),
    .wrap_in (cfg_wrap),
    .count   (count),
    .last    (cnt_last),
    .wrap_q  (wrap_q)
  );

  assign fill_count = count;
  assign wr_addr    = count[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Loss of buffer_ready outranks every other condition once a fill is under way.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wr_en     = 1'b0;
    ready     = 1'b0;
    clear     = 1'b0;
    done      = 1'b0;
    cnt_load  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        clear = !buffer_ready;
        if (en && buffer_ready) begin
          state_nxt = S_START;
          cnt_load  = 1'b1;
        end
      end
      S_START: begin
        if (en) begin
          if (!buffer_ready) begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
          end else if (!empty) begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        ready = 1'b1;
        if (en) begin
          if (!buffer_ready) begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
          end else if (empty) begin
            state_nxt = S_START;
          end else begin
            pop     = 1'b1;
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_last && !wrap_q) begin
              state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (en && !buffer_ready) begin
          state_nxt = S_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/spad_fill_ctrl.md
SPAD_FILL_CTRL -- requirements
Module: spad_fill_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 12, meaning number of scratchpad entries (>=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), meaning scratchpad address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  global enable; 0 freezes state and counter.
REQ-006 SHALL have port buffer_ready  input  1  upstream buffer holds a valid fill request; deassertion aborts.
REQ-007 SHALL have port empty  input  1  source FIFO empty flag.
REQ-008 SHALL have port cfg_len  input  ADDR_WIDTH+1  number of entries to write; sampled on leaving S_IDLE.
REQ-009 SHALL have port cfg_wrap  input  1  1 = continuous ring fill, 0 = one-shot fill; sampled with cfg_len.
REQ-010 SHALL have port pop  output  1  FIFO read strobe.
REQ-011 SHALL have port wr_en  output  1  scratchpad write strobe.
REQ-012 SHALL have port wr_addr  output  ADDR_WIDTH  scratchpad write address.
REQ-013 SHALL have port ready  output  1  controller is in S_WRITE.
REQ-014 SHALL have port clear  output  1  scratchpad clear request.
REQ-015 SHALL have port done  output  1  one-shot fill complete.
REQ-016 SHALL have port fill_count  output  ADDR_WIDTH+1  entries written in current pass.

Function
REQ-017 SHALL implement states S_IDLE, S_START, S_WRITE, S_DONE.
REQ-018 S_IDLE: clear = !buffer_ready; on buffer_ready -> S_START, latch len_q and wrap_q, counter = 0.
REQ-019 len_q SHALL be DEPTH when cfg_len is 0 or cfg_len > DEPTH, else cfg_len.
REQ-020 S_START: -> S_WRITE when !empty, else remain.
REQ-021 S_WRITE: ready = 1; pop = wr_en = en & !empty, same cycle (zero latency, combinational); wr_addr = counter.
REQ-022 Each cycle with wr_en = 1, counter SHALL increment by 1 at the next edge.
REQ-023 S_WRITE with empty = 1: -> S_START, counter held, no write.
REQ-024 Write at counter = len_q-1 with wrap_q = 0: -> S_DONE, done = 1 from next cycle; counter saturates at len_q.
REQ-025 Write at counter = len_q-1 with wrap_q = 1: counter wraps to 0, stay in S_WRITE; done never asserted.
REQ-026 S_DONE: pop = wr_en = 0, done = 1; exit to S_IDLE only on !buffer_ready.
REQ-027 !buffer_ready in S_START, S_WRITE or S_DONE SHALL take priority over all other conditions: -> S_IDLE, counter = 0, no write that cycle.
REQ-028 en = 0 SHALL hold state, counter, len_q, wrap_q and force pop = wr_en = 0; clear and done still reflect held state.
REQ-029 fill_count SHALL equal counter; wr_addr = counter[ADDR_WIDTH-1:0].
REQ-030 pop and wr_en SHALL never be asserted outside S_WRITE.

Reset
REQ-031 rstn = 0 SHALL immediately force S_IDLE, counter = 0, len_q = DEPTH, wrap_q = 0, done = 0.
REQ-032 Reset mid-fill SHALL drop pop/wr_en asynchronously; no partial write after deassertion.
REQ-033 After reset release, clear = !buffer_ready, all other outputs 0.

Structure
REQ-034 State encoding (2-bit localparams S_IDLE..S_DONE) SHALL live in shared package spad_pkg.
REQ-035 Address/length counter SHALL be sub-module spad_addr_counter (load, inc, wrap, saturate).
REQ-036 FSM and output decode SHALL stay in spad_fill_ctrl; no other sub-modules.

Verification
REQ-037 DEPTH=12, cfg_len=4, wrap=0, empty=0 continuous -> wr_addr 0,1,2,3 on 4 consecutive cycles, then done=1, pop=0.
REQ-038 cfg_len=3, wrap=1, empty=0 for 7 writes -> wr_addr 0,1,2,0,1,2,0; done stays 0.
REQ-039 cfg_len=4, empty pulses 1 after 2nd write for 3 cycles -> state S_START, no pop; resume at wr_addr 2.
REQ-040 buffer_ready drops at wr_addr 2 -> no write that cycle, S_IDLE next, clear=1, fill_count=0.
REQ-041 cfg_len=0 and cfg_len=20 with DEPTH=12 -> 12 writes, addr 0..11, then done=1.
REQ-042 en=0 for 2 cycles mid-fill, then rstn pulse -> counter held during en=0; all outputs reset immediately on rstn=0.
